// File: rtl/demux_1x3_buf_if.sv
// ---------------------------------------------------------------------------
// demux_1x3_buf_if
//   Bundle of the input stream, the three output queue ports and the status
//   flags of demux_1x3_buf.
//   slave  : view used by the router itself.
//   master : view used by whoever drives the input stream and consumes the
//            three output ports (producer plus consumers A/B/C).
//   Signals:
//     i_valid / o_ready / i_sel / i_data       input stream and destination
//     o_x_valid / i_x_ready / o_x_data (x=a,b,c) per-queue head port
//     o_busy                                   any queue non-empty
//     o_err                                    sticky illegal-select flag
// ---------------------------------------------------------------------------
interface demux_1x3_buf_if #(
  parameter int DW = 32
);
  logic          i_valid;
  logic          o_ready;
  logic [1:0]    i_sel;
  logic [DW-1:0] i_data;

  logic          o_a_valid;
  logic          i_a_ready;
  logic [DW-1:0] o_a_data;
  logic          o_b_valid;
  logic          i_b_ready;
  logic [DW-1:0] o_b_data;
  logic          o_c_valid;
  logic          i_c_ready;
  logic [DW-1:0] o_c_data;

  logic          o_busy;
  logic          o_err;

  modport slave (
    input  i_valid, i_sel, i_data,
    output o_ready,
    output o_a_valid, o_a_data, input i_a_ready,
    output o_b_valid, o_b_data, input i_b_ready,
    output o_c_valid, o_c_data, input i_c_ready,
    output o_busy, o_err
  );

  modport master (
    output i_valid, i_sel, i_data,
    input  o_ready,
    input  o_a_valid, o_a_data, output i_a_ready,
    input  o_b_valid, o_b_data, output i_b_ready,
    input  o_c_valid, o_c_data, output i_c_ready,
    input  o_busy, o_err
  );
endinterface

// File: rtl/demux_1x3_buf.sv
// ---------------------------------------------------------------------------
// demux_1x3_buf
//   Buffered 1-to-3 word router. Each input beat is steered by its 2-bit
//   select into one of three independent DEPTH-entry queues (A/B/C); each
//   queue drains through its own valid/ready port with the head taken
//   directly from storage, so an accepted beat is visible on an empty
//   queue's port the following cycle.
//
//   Ports:
//     i_clk    clock, rising edge
//     i_rst_n  asynchronous active-low reset (drops all queued beats)
//     bus      demux_1x3_buf_if.slave: input stream, three head ports,
//              o_busy (any queue non-empty), o_err (sticky illegal select)
//
//   Parameters:
//     DW     data width
//     DEPTH  entries per queue, power of 2 and >= 2
//
//   Build option:
//     DEMUX_ILLEGAL_DROP_EN  when defined, a sel=11 beat is accepted and
//                            discarded and sets the sticky o_err flag.
//                            When undefined, sel=11 routes to queue A and
//                            o_err is tied to 0.
// ---------------------------------------------------------------------------
module demux_1x3_buf #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input logic               i_clk,
  input logic               i_rst_n,
  demux_1x3_buf_if.slave    bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam int NQ = 3;

  // Per-queue state
  logic [PW-1:0] wr_ptr_q [NQ];
  logic [PW-1:0] wr_ptr_d [NQ];
  logic [PW-1:0] rd_ptr_q [NQ];
  logic [PW-1:0] rd_ptr_d [NQ];
  logic [CW-1:0] count_q  [NQ];
  logic [CW-1:0] count_d  [NQ];
  logic [DW-1:0] mem_q    [NQ][DEPTH];

  logic [NQ-1:0] cons_ready;
  logic [NQ-1:0] head_valid;
  logic [NQ-1:0] push;
  logic [NQ-1:0] pop;

  logic [1:0]    dest;
  logic          drop;
  logic          ready;

  assign cons_ready = {bus.i_c_ready, bus.i_b_ready, bus.i_a_ready};

  // Destination decode. An out-of-range dest only ever occurs together
  // with drop, in which case no queue is addressed.
  // NOTE: every signal driven from always_comb gets a default on entry so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    dest = bus.i_sel;
    drop = 1'b0;
`ifdef DEMUX_ILLEGAL_DROP_EN
    if (bus.i_sel == 2'b11) drop = 1'b1;
`else
    if (bus.i_sel == 2'b11) dest = 2'b00;
`endif
  end

  always_comb begin
    for (int q = 0; q < NQ; q++) begin
      head_valid[q] = (count_q[q] != '0);
      pop[q]        = head_valid[q] & cons_ready[q];
    end
  end

  // A full queue still accepts when its head leaves in the same cycle.
  always_comb begin
    ready = 1'b0;
    for (int q = 0; q < NQ; q++) begin
      if (dest == 2'(q)) ready = (count_q[q] != FULL) | pop[q];
    end
    if (drop) ready = 1'b1;
  end

  always_comb begin
    for (int q = 0; q < NQ; q++) begin
      push[q] = bus.i_valid & ready & ~drop & (dest == 2'(q));
    end
  end

  // Pointer and count next state; pointers wrap naturally at DEPTH.
  always_comb begin
    for (int q = 0; q < NQ; q++) begin
      wr_ptr_d[q] = wr_ptr_q[q];
      rd_ptr_d[q] = rd_ptr_q[q];
      count_d[q]  = count_q[q];
      if (push[q]) wr_ptr_d[q] = wr_ptr_q[q] + PW'(1);
      if (pop[q])  rd_ptr_d[q] = rd_ptr_q[q] + PW'(1);
      case ({push[q], pop[q]})
        2'b10:   count_d[q] = count_q[q] + CW'(1);
        2'b01:   count_d[q] = count_q[q] - CW'(1);
        default: count_d[q] = count_q[q];
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // registers sample their inputs from the same pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int q = 0; q < NQ; q++) begin
        wr_ptr_q[q] <= '0;
        rd_ptr_q[q] <= '0;
        count_q[q]  <= '0;
      end
    end else begin
      for (int q = 0; q < NQ; q++) begin
        wr_ptr_q[q] <= wr_ptr_d[q];
        rd_ptr_q[q] <= rd_ptr_d[q];
        count_q[q]  <= count_d[q];
      end
    end
  end

  // NOTE: the storage is reset because the head ports read it directly and
  // must show zero data out of reset; with DEPTH entries this stays small.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int q = 0; q < NQ; q++) begin
        for (int e = 0; e < DEPTH; e++) mem_q[q][e] <= '0;
      end
    end else begin
      for (int q = 0; q < NQ; q++) begin
        if (push[q]) mem_q[q][wr_ptr_q[q]] <= bus.i_data;
      end
    end
  end

`ifdef DEMUX_ILLEGAL_DROP_EN
  logic err_q;
  logic err_d;

  assign err_d = err_q | (bus.i_valid & drop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
`endif

  assign bus.o_ready   = ready;
  assign bus.o_a_valid = head_valid[0];
  assign bus.o_b_valid = head_valid[1];
  assign bus.o_c_valid = head_valid[2];
  assign bus.o_a_data  = mem_q[0][rd_ptr_q[0]];
  assign bus.o_b_data  = mem_q[1][rd_ptr_q[1]];
  assign bus.o_c_data  = mem_q[2][rd_ptr_q[2]];
  assign bus.o_busy    = |head_valid;

endmodule

// File: tb/tb_demux_1x3_buf.sv
// ---------------------------------------------------------------------------
// tb_demux_1x3_buf
//   Directed bench for demux_1x3_buf (DW=32, DEPTH=2). Inputs change 1 time
//   unit after the rising edge; outputs are sampled on the falling edge.
//   The sel=11 expectations follow DEMUX_ILLEGAL_DROP_EN.
// ---------------------------------------------------------------------------
module tb_demux_1x3_buf;

  localparam int DW = 32;

  logic clk;
  logic rst_n;

  demux_1x3_buf_if #(.DW(DW)) bus ();

  demux_1x3_buf #(.DW(DW), .DEPTH(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One cycle of stimulus and the outputs expected before the next edge.
  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [31:0] d;
    logic [2:0]  rdy;    // {c, b, a}
    logic        e_rdy;
    logic [2:0]  e_vld;  // {c, b, a}
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [31:0] e_c;
    logic        e_busy;
  } vec_t;

  function automatic vec_t mk(logic v, logic [1:0] sel, logic [31:0] d,
                              logic [2:0] rdy, logic e_rdy, logic [2:0] e_vld,
                              logic [31:0] e_a, logic [31:0] e_b,
                              logic [31:0] e_c, logic e_busy);
    vec_t r;
    r.v = v; r.sel = sel; r.d = d; r.rdy = rdy; r.e_rdy = e_rdy;
    r.e_vld = e_vld; r.e_a = e_a; r.e_b = e_b; r.e_c = e_c; r.e_busy = e_busy;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [1:0] sel,
                       input logic [31:0] d, input logic [2:0] rdy);
    bus.i_valid   = v;
    bus.i_sel     = sel;
    bus.i_data    = d;
    bus.i_a_ready = rdy[0];
    bus.i_b_ready = rdy[1];
    bus.i_c_ready = rdy[2];
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [21];

  // Watchdog: a hung run still reports before stopping.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   q_model[$];
    int   sent;
    int   got;
    int   cyc;
    logic ar;
    logic exp_rdy;

    // Routing (0-4), backpressure on B (5-11), independence of A from a
    // stalled full B (12-20).
    vecs[0]  = mk(1, 2'd0, 32'hA0, 3'b111, 1, 3'b000, 0,     0,     0,     0);
    vecs[1]  = mk(1, 2'd1, 32'hB0, 3'b111, 1, 3'b001, 32'hA0, 0,    0,     1);
    vecs[2]  = mk(1, 2'd2, 32'hC0, 3'b111, 1, 3'b010, 0,     32'hB0, 0,    1);
    vecs[3]  = mk(0, 2'd0, 32'h0,  3'b111, 1, 3'b100, 0,     0,     32'hC0, 1);
    vecs[4]  = mk(0, 2'd0, 32'h0,  3'b111, 1, 3'b000, 0,     0,     0,     0);
    vecs[5]  = mk(1, 2'd1, 32'h1,  3'b101, 1, 3'b000, 0,     0,     0,     0);
    vecs[6]  = mk(1, 2'd1, 32'h2,  3'b101, 1, 3'b010, 0,     32'h1, 0,     1);
    vecs[7]  = mk(1, 2'd1, 32'h3,  3'b101, 0, 3'b010, 0,     32'h1, 0,     1);
    vecs[8]  = mk(1, 2'd1, 32'h3,  3'b111, 1, 3'b010, 0,     32'h1, 0,     1);
    vecs[9]  = mk(0, 2'd0, 32'h0,  3'b111, 1, 3'b010, 0,     32'h2, 0,     1);
    vecs[10] = mk(0, 2'd0, 32'h0,  3'b111, 1, 3'b010, 0,     32'h3, 0,     1);
    vecs[11] = mk(0, 2'd0, 32'h0,  3'b111, 1, 3'b000, 0,     0,     0,     0);
    vecs[12] = mk(1, 2'd1, 32'h21, 3'b101, 1, 3'b000, 0,     0,     0,     0);
    vecs[13] = mk(1, 2'd1, 32'h22, 3'b101, 1, 3'b010, 0,     32'h21, 0,    1);
    vecs[14] = mk(1, 2'd0, 32'h5,  3'b101, 1, 3'b010, 0,     32'h21, 0,    1);
    vecs[15] = mk(1, 2'd0, 32'h6,  3'b101, 1, 3'b011, 32'h5, 32'h21, 0,    1);
    vecs[16] = mk(1, 2'd1, 32'h23, 3'b101, 0, 3'b011, 32'h6, 32'h21, 0,    1);
    vecs[17] = mk(1, 2'd1, 32'h23, 3'b111, 1, 3'b010, 0,     32'h21, 0,    1);
    vecs[18] = mk(0, 2'd0, 32'h0,  3'b111, 1, 3'b010, 0,     32'h22, 0,    1);
    vecs[19] = mk(0, 2'd0, 32'h0,  3'b111, 1, 3'b010, 0,     32'h23, 0,    1);
    vecs[20] = mk(0, 2'd0, 32'h0,  3'b111, 1, 3'b000, 0,     0,     0,     0);

    // ---- Reset with a beat presented: nothing may be queued.
    rst_n = 1'b0;
    drive(1, 2'd0, 32'h11, 3'b111);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst a_valid", 32'(bus.o_a_valid), 0);
    check("rst b_valid", 32'(bus.o_b_valid), 0);
    check("rst c_valid", 32'(bus.o_c_valid), 0);
    check("rst a_data",  bus.o_a_data, 0);
    check("rst busy",    32'(bus.o_busy), 0);
    check("rst err",     32'(bus.o_err), 0);
    rst_n = 1'b1;
    next_cycle();
    drive(0, 2'd0, 32'h0, 3'b111);
    @(negedge clk);
    check("post_rst a_valid", 32'(bus.o_a_valid), 1);
    check("post_rst a_data",  bus.o_a_data, 32'h11);
    check("post_rst busy",    32'(bus.o_busy), 1);
    next_cycle();
    @(negedge clk);
    check("post_rst drained", 32'(bus.o_a_valid), 0);
    next_cycle();

    // ---- Table-driven vectors.
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].rdy);
      @(negedge clk);
      check($sformatf("vec%0d ready", i), 32'(bus.o_ready), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d valids", i),
            32'({bus.o_c_valid, bus.o_b_valid, bus.o_a_valid}), 32'(vecs[i].e_vld));
      check($sformatf("vec%0d busy", i), 32'(bus.o_busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_vld[0]) check($sformatf("vec%0d a_data", i), bus.o_a_data, vecs[i].e_a);
      if (vecs[i].e_vld[1]) check($sformatf("vec%0d b_data", i), bus.o_b_data, vecs[i].e_b);
      if (vecs[i].e_vld[2]) check($sformatf("vec%0d c_data", i), bus.o_c_data, vecs[i].e_c);
      next_cycle();
    end

    // ---- Mid-operation reset drops a queued beat immediately.
    drive(1, 2'd1, 32'h31, 3'b101);
    next_cycle();
    drive(0, 2'd0, 32'h0, 3'b101);
    @(negedge clk);
    check("midrst b_valid before", 32'(bus.o_b_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst b_valid async", 32'(bus.o_b_valid), 0);
    check("midrst busy async",    32'(bus.o_busy), 0);
    next_cycle();
    rst_n = 1'b1;
    drive(0, 2'd0, 32'h0, 3'b111);
    @(negedge clk);
    check("midrst b_valid after", 32'(bus.o_b_valid), 0);
    next_cycle();

    // ---- Wrap: 10 beats through A with random consumer ready, against a
    // queue model bounded at two entries.
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((sent < 10 || q_model.size() > 0) && cyc < 200) begin
      ar = 1'($urandom_range(0, 1));
      drive(sent < 10, 2'd0, 32'h100 + 32'(sent), {2'b11, ar});
      exp_rdy = (q_model.size() < 2) || ar;
      @(negedge clk);
      check($sformatf("wrap%0d ready", cyc), 32'(bus.o_ready), 32'(exp_rdy));
      check($sformatf("wrap%0d a_valid", cyc), 32'(bus.o_a_valid),
            32'(q_model.size() > 0));
      check($sformatf("wrap%0d busy", cyc), 32'(bus.o_busy), 32'(q_model.size() > 0));
      if (q_model.size() > 0)
        check($sformatf("wrap%0d a_data", cyc), bus.o_a_data, 32'(q_model[0]));
      next_cycle();
      if (q_model.size() > 0 && ar) begin
        void'(q_model.pop_front());
        got++;
      end
      if (bus.i_valid && exp_rdy) begin
        q_model.push_back(32'h100 + sent);
        sent++;
      end
      cyc++;
    end
    check("wrap drained", 32'(got), 10);

    // ---- Illegal select 11 with beat 0xDEAD, A consumer stalled.
    drive(1, 2'd3, 32'hDEAD, 3'b110);
    @(negedge clk);
    check("sel11 ready", 32'(bus.o_ready), 1);
    next_cycle();
    drive(0, 2'd0, 32'h0, 3'b110);
    @(negedge clk);
    check("sel11 b_valid", 32'(bus.o_b_valid), 0);
    check("sel11 c_valid", 32'(bus.o_c_valid), 0);
`ifdef DEMUX_ILLEGAL_DROP_EN
    check("sel11 a_valid", 32'(bus.o_a_valid), 0);
    check("sel11 busy",    32'(bus.o_busy), 0);
    check("sel11 err",     32'(bus.o_err), 1);
    next_cycle();
    @(negedge clk);
    check("sel11 err sticky", 32'(bus.o_err), 1);
`else
    check("sel11 a_valid", 32'(bus.o_a_valid), 1);
    check("sel11 a_data",  bus.o_a_data, 32'hDEAD);
    check("sel11 err",     32'(bus.o_err), 0);
    next_cycle();
    @(negedge clk);
    check("sel11 a_held",  32'(bus.o_a_valid), 1);
    check("sel11 err off", 32'(bus.o_err), 0);
`endif
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
